esp_uart_bus: RTL and testbench
===============================

ESP_UART_BUS -- requirements
Module: esp_uart_bus

Interface
REQ-001 SHALL have port clk, input, 1, system clock (28.63636 MHz); all logic in this single clock domain.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port bus_addr, input, 2, CPU word address bits [3:2] selecting the register.
REQ-004 SHALL have ports bus_wrdata (input, 32, write data), bus_bytesel (input, 4, byte lanes), bus_wren (input, 1, write) and bus_strobe (input, 1, access request, already decoded).
REQ-005 SHALL have ports bus_wait (output, 1, stall) and bus_rddata (output, 32, read data).
REQ-006 SHALL have ports txfifo_data (output, 9), txfifo_wr (output, 1) and txfifo_full (input, 1), connecting to the UART TX FIFO.
REQ-007 SHALL have ports rxfifo_data (input, 9, show-ahead head), rxfifo_rd (output, 1, pop), rxfifo_empty (input, 1), rxfifo_overflow (input, 1, pulse) and rx_framing_error (input, 1, pulse).
REQ-008 SHALL have port irq, output, 1, level interrupt to the CPU irq vector.

Function
REQ-009 SHALL complete an access in the cycle where bus_strobe=1 and bus_wait=0; bus_rddata SHALL be combinational and valid in that cycle.
REQ-010 SHALL decode bus_addr 0=STATUS, 1=DATA, 2=CTRL, 3=reserved (reads 0, writes ignored).
REQ-011 SHALL return STATUS = {27'b0, irq, framing_sticky, overflow_sticky, txfifo_full, rx_valid}.
REQ-012 SHALL clear overflow_sticky when STATUS is written with bit2=1 and framing_sticky when bit3=1, only when bus_bytesel[0]=1.
REQ-013 SHALL prioritise setting a sticky flag over clearing it in the same cycle.
REQ-014 SHALL hold one RX holding register (9 bits + rx_valid flag).
REQ-015 SHALL, when rx_valid=0 or a DATA read completes this cycle, and rxfifo_empty=0, pulse rxfifo_rd for 1 cycle and load rxfifo_data into the holding register, setting rx_valid=1.
REQ-016 SHALL, on a completed DATA read with rx_valid=1, return {23'b0, hold} and clear rx_valid unless it is refilled in the same cycle per REQ-015.
REQ-017 SHALL return 0 on a DATA read with rx_valid=0, with no side effects.
REQ-018 SHALL never assert rxfifo_rd while rxfifo_empty=1.
REQ-019 SHALL handle a DATA write with bus_bytesel[0]=1 by asserting bus_wait while txfifo_full=1, then pulsing txfifo_wr for exactly 1 cycle with txfifo_data=bus_wrdata[8:0] in the completing cycle.
REQ-020 SHALL ignore DATA writes with bus_bytesel[0]=0, completing them without wait.
REQ-021 SHALL set bus_wait=0 for all accesses except a TX write to a full FIFO, and SHALL force bus_wait=0 whenever bus_strobe=0.
REQ-022 SHALL implement CTRL bit0 (rx_irq_en) and bit1 (err_irq_en), writable when bus_bytesel[0]=1; reads return {30'b0, ctrl}.
REQ-023 SHALL register irq = (rx_irq_en & rx_valid) | (err_irq_en & (overflow_sticky | framing_sticky)), with 1 cycle latency.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously clear rx_valid, hold, both sticky flags, ctrl and irq; txfifo_wr=0, rxfifo_rd=0, bus_wait=0, bus_rddata=0.
REQ-025 SHALL, on reset asserted mid-stall, abort the pending TX write without issuing txfifo_wr.

Configuration
REQ-026 SHALL, when macro ESP_UART_IRQ_EN is defined, implement CTRL and irq per REQ-022/023.
REQ-027 SHALL, when ESP_UART_IRQ_EN is undefined, tie irq to 0, make CTRL read 0 with writes ignored, and force STATUS bit4 to 0.

Verification
REQ-028 SHALL verify RX prefetch: push 0x041 into a model RX FIFO -> one rxfifo_rd pulse, STATUS reads 0x01, DATA read returns 0x041, then STATUS reads 0x00.
REQ-029 SHALL verify back-to-back RX: FIFO holds 0x101, 0x002 -> consecutive DATA reads return 0x101 then 0x002, with rx_valid refilled in the pop cycle.
REQ-030 SHALL verify TX stall: txfifo_full=1 for 5 cycles during a DATA write of 0x1AA -> bus_wait=1 for 5 cycles, then a single txfifo_wr with txfifo_data=0x1AA.
REQ-031 SHALL verify errors: overflow pulse -> STATUS bit2=1; write 0x4 to STATUS -> bit2=0; a coincident pulse and clear leaves bit2=1.
REQ-032 SHALL verify irq: CTRL=0x1, one RX byte -> irq=1 one cycle after rx_valid; after the DATA read, irq=0; without ESP_UART_IRQ_EN, irq stays 0.
REQ-033 SHALL verify reset: reset_n=0 while a stalled TX write is pending -> outputs at reset values immediately and no txfifo_wr issued.

Source files
------------

// File: rtl/esp_uart_bus.sv
// ---------------------------------------------------------------------------
// esp_uart_bus
//
// CPU bus front end for the UART. It presents four word registers selected
// by bus_addr (STATUS, DATA, CTRL, reserved) and connects them to the UART
// TX FIFO and the show-ahead RX FIFO. One RX byte is prefetched into a
// holding register, so a DATA read returns data without waiting.
//
// Optional feature: define ESP_UART_IRQ_EN to build the CTRL register and
// the irq output. Without it irq is tied low, CTRL reads 0, and STATUS
// bit4 reads 0.
//
// Ports
//   clk              system clock (single clock domain)
//   reset_n          asynchronous active-low reset
//   bus_addr         word address bits [3:2]: 0=STATUS 1=DATA 2=CTRL 3=rsvd
//   bus_wrdata       write data
//   bus_bytesel      byte lane enables (only lane 0 is significant)
//   bus_wren         1 = write, 0 = read
//   bus_strobe       access request, already decoded for this block
//   bus_wait         stall; only for a TX write into a full TX FIFO
//   bus_rddata       combinational read data, valid in the completing cycle
//   txfifo_data      byte (9 bits) pushed into the TX FIFO
//   txfifo_wr        TX FIFO push strobe
//   txfifo_full      TX FIFO full flag
//   rxfifo_data      RX FIFO show-ahead head entry
//   rxfifo_rd        RX FIFO pop strobe
//   rxfifo_empty     RX FIFO empty flag
//   rxfifo_overflow  RX FIFO overflow pulse
//   rx_framing_error receiver framing error pulse
//   irq              level interrupt to the CPU
// ---------------------------------------------------------------------------
module esp_uart_bus (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic [3:0]  bus_bytesel,
    input  logic        bus_wren,
    input  logic        bus_strobe,
    output logic        bus_wait,
    output logic [31:0] bus_rddata,
    output logic [8:0]  txfifo_data,
    output logic        txfifo_wr,
    input  logic        txfifo_full,
    input  logic [8:0]  rxfifo_data,
    output logic        rxfifo_rd,
    input  logic        rxfifo_empty,
    input  logic        rxfifo_overflow,
    input  logic        rx_framing_error,
    output logic        irq
);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [8:0] hold_q,       hold_d;
    logic       rx_valid_q,   rx_valid_d;
    logic       overflow_q,   overflow_d;
    logic       framing_q,    framing_d;
    logic [1:0] ctrlValue;
    logic       irqValue;

    logic statusWr;
    logic dataRd;
    logic txReq;
    logic rxLoad;

    // Only lane 0 and the low nine data bits carry register content.
    logic unusedBits;
    assign unusedBits = ^{bus_wrdata[31:9], bus_bytesel[3:1]};

    // Access decode. Reads never stall, so a read strobe is a completed read.
    assign statusWr = bus_strobe & bus_wren & bus_bytesel[0] & (bus_addr == ADDR_STATUS);
    assign dataRd   = bus_strobe & ~bus_wren & (bus_addr == ADDR_DATA);
    assign txReq    = bus_strobe & bus_wren & bus_bytesel[0] & (bus_addr == ADDR_DATA);

    // Refill the holding register whenever it is free or being emptied by
    // this cycle's DATA read. Gated by reset_n so no pop escapes during reset.
    assign rxLoad = reset_n & ~rxfifo_empty & (~rx_valid_q | dataRd);

    // TX handshake is purely combinational: the push happens in the cycle the
    // write completes, so dropping reset_n mid-stall simply aborts it.
    assign bus_wait    = reset_n & txReq & txfifo_full;
    assign txfifo_wr   = reset_n & txReq & ~txfifo_full;
    assign txfifo_data = bus_wrdata[8:0];
    assign rxfifo_rd   = rxLoad;

    // Next-state for the RX holding register and the sticky error flags.
    // A sticky flag is set in preference to being cleared in the same cycle.
    always_comb begin
        hold_d     = hold_q;
        rx_valid_d = rx_valid_q;
        if (rxLoad) begin
            hold_d     = rxfifo_data;
            rx_valid_d = 1'b1;
        end else if (dataRd) begin
            rx_valid_d = 1'b0;
        end

        overflow_d = overflow_q;
        if (rxfifo_overflow) begin
            overflow_d = 1'b1;
        end else if (statusWr && bus_wrdata[2]) begin
            overflow_d = 1'b0;
        end

        framing_d = framing_q;
        if (rx_framing_error) begin
            framing_d = 1'b1;
        end else if (statusWr && bus_wrdata[3]) begin
            framing_d = 1'b0;
        end
    end

    // State register for the RX path and error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            rx_valid_q <= rx_valid_d;
            overflow_q <= overflow_d;
            framing_q  <= framing_d;
        end
    end

`ifdef ESP_UART_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q,  irq_d;
    logic       ctrlWr;

    assign ctrlWr = bus_strobe & bus_wren & bus_bytesel[0] & (bus_addr == ADDR_CTRL);

    // CTRL bit0 enables the RX-data interrupt, bit1 the error interrupt.
    // irq is registered, so it follows its sources by one cycle.
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrlWr) begin
            ctrl_d = bus_wrdata[1:0];
        end
        irq_d = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & (overflow_q | framing_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrlValue = ctrl_q;
    assign irqValue  = irq_q;
`else
    assign ctrlValue = 2'b00;
    assign irqValue  = 1'b0;
`endif

    assign irq = irqValue;

    // Combinational read mux; returns zero outside a read and during reset.
    always_comb begin
        bus_rddata = '0;
        if (reset_n && bus_strobe && !bus_wren) begin
            case (bus_addr)
                ADDR_STATUS: bus_rddata = {27'b0, irqValue, framing_q, overflow_q,
                                           txfifo_full, rx_valid_q};
                ADDR_DATA:   bus_rddata = rx_valid_q ? {23'b0, hold_q} : 32'b0;
                ADDR_CTRL:   bus_rddata = {30'b0, ctrlValue};
                default:     bus_rddata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_esp_uart_bus.sv
// ---------------------------------------------------------------------------
// tb_esp_uart_bus
//
// Directed self-checking bench for esp_uart_bus. A small model RX FIFO
// (show-ahead, popped on rxfifo_rd) feeds the design, and a monitor counts
// TX FIFO pushes. Inputs change on the falling clock edge and outputs are
// sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_esp_uart_bus;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_wrdata = '0;
    logic [3:0]  bus_bytesel = '0;
    logic        bus_wren = 1'b0;
    logic        bus_strobe = 1'b0;
    logic        bus_wait;
    logic [31:0] bus_rddata;
    logic [8:0]  txfifo_data;
    logic        txfifo_wr;
    logic        txfifo_full = 1'b0;
    logic [8:0]  rxfifo_data;
    logic        rxfifo_rd;
    logic        rxfifo_empty;
    logic        rxfifo_overflow = 1'b0;
    logic        rx_framing_error = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Model RX FIFO storage; written only by pushRx, popped only by the monitor.
    logic [8:0] rxMem [0:7];
    logic [3:0] rxWrPtr = '0;
    logic [3:0] rxRdPtr = '0;
    int         rdCount = 0;
    int         txCount = 0;
    logic [8:0] txLast = '0;

    assign rxfifo_data  = rxMem[rxRdPtr[2:0]];
    assign rxfifo_empty = (rxRdPtr == rxWrPtr);

    always #5 clk = ~clk;

    esp_uart_bus dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus_addr         (bus_addr),
        .bus_wrdata       (bus_wrdata),
        .bus_bytesel      (bus_bytesel),
        .bus_wren         (bus_wren),
        .bus_strobe       (bus_strobe),
        .bus_wait         (bus_wait),
        .bus_rddata       (bus_rddata),
        .txfifo_data      (txfifo_data),
        .txfifo_wr        (txfifo_wr),
        .txfifo_full      (txfifo_full),
        .rxfifo_data      (rxfifo_data),
        .rxfifo_rd        (rxfifo_rd),
        .rxfifo_empty     (rxfifo_empty),
        .rxfifo_overflow  (rxfifo_overflow),
        .rx_framing_error (rx_framing_error),
        .irq              (irq)
    );

    // Monitor: pop the model FIFO on rxfifo_rd and record TX pushes.
    always @(posedge clk) begin
        if (rxfifo_rd) begin
            rxRdPtr <= rxRdPtr + 4'd1;
            rdCount <= rdCount + 1;
        end
        if (txfifo_wr) begin
            txCount <= txCount + 1;
            txLast  <= txfifo_data;
        end
    end

    task automatic pushRx(input logic [8:0] v);
        rxMem[rxWrPtr[2:0]] = v;
        rxWrPtr = rxWrPtr + 4'd1;
    endtask

    task automatic busSet(input logic [1:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus_addr    = a;
        bus_wren    = w;
        bus_wrdata  = d;
        bus_bytesel = be;
        bus_strobe  = 1'b1;
        #1;
    endtask

    task automatic busIdle();
        @(negedge clk);
        bus_strobe  = 1'b0;
        bus_wren    = 1'b0;
        bus_bytesel = '0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus_wait !== 1'b0 || txfifo_wr !== 1'b0 || rxfifo_rd !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got wait=%b wr=%b rd=%b irq=%b, expected all 0",
                     bus_wait, txfifo_wr, rxfifo_rd, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_status: got %h expected %h", bus_rddata, 32'h0);
        end
        busSet(2'd2, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %h expected %h", bus_rddata, 32'h0);
        end
        busSet(2'd1, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0 || rxfifo_rd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_data_read: got %h rd=%b expected 0 rd=0", bus_rddata, rxfifo_rd);
        end
        busIdle();
    endtask

    task automatic test_rx_prefetch();
        int startRd;
        startRd = rdCount;
        @(negedge clk);
        pushRx(9'h041);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (rdCount - startRd !== 1) begin
            failures++;
            $display("[TB] FAIL prefetch_pops: got %0d expected 1", rdCount - startRd);
        end
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h1) begin
            failures++;
            $display("[TB] FAIL prefetch_status: got %h expected %h", bus_rddata, 32'h1);
        end
        busSet(2'd1, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h041) begin
            failures++;
            $display("[TB] FAIL prefetch_data: got %h expected %h", bus_rddata, 32'h041);
        end
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL prefetch_status_after: got %h expected %h", bus_rddata, 32'h0);
        end
        busIdle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pushRx(9'h101);
        pushRx(9'h002);
        busSet(2'd1, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h101 || rxfifo_rd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h rd=%b expected 00000101 rd=1", bus_rddata, rxfifo_rd);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus_rddata !== 32'h002 || rxfifo_rd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h rd=%b expected 00000002 rd=0", bus_rddata, rxfifo_rd);
        end
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL b2b_status_after: got %h expected %h", bus_rddata, 32'h0);
        end
        busIdle();
    endtask

    task automatic test_tx_stall();
        int startTx;
        startTx = txCount;
        @(negedge clk);
        txfifo_full = 1'b1;
        busSet(2'd1, 1'b1, 32'h155, 4'b1110);
        checks++;
        if (bus_wait !== 1'b0 || txfifo_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tx_lane_masked: got wait=%b wr=%b expected 0 0", bus_wait, txfifo_wr);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                busSet(2'd1, 1'b1, 32'h1AA, 4'h1);
            end else begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (bus_wait !== 1'b1 || txfifo_wr !== 1'b0) begin
                failures++;
                $display("[TB] FAIL tx_stall_cycle%0d: got wait=%b wr=%b expected 1 0", i, bus_wait, txfifo_wr);
            end
        end
        @(negedge clk);
        txfifo_full = 1'b0;
        #1;
        checks++;
        if (bus_wait !== 1'b0 || txfifo_wr !== 1'b1 || txfifo_data !== 9'h1AA) begin
            failures++;
            $display("[TB] FAIL tx_complete: got wait=%b wr=%b data=%h expected 0 1 1aa",
                     bus_wait, txfifo_wr, txfifo_data);
        end
        busIdle();
        checks++;
        if (txCount - startTx !== 1 || txLast !== 9'h1AA) begin
            failures++;
            $display("[TB] FAIL tx_push_count: got %0d pushes last=%h expected 1 last=1aa",
                     txCount - startTx, txLast);
        end
    endtask

    task automatic test_errors();
        @(negedge clk);
        rxfifo_overflow = 1'b1;
        @(negedge clk);
        rxfifo_overflow = 1'b0;
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h4) begin
            failures++;
            $display("[TB] FAIL overflow_set: got %h expected %h", bus_rddata, 32'h4);
        end
        busSet(2'd0, 1'b1, 32'h4, 4'h1);
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL overflow_clear: got %h expected %h", bus_rddata, 32'h0);
        end
        busSet(2'd0, 1'b1, 32'h4, 4'h1);
        rxfifo_overflow = 1'b1;
        @(negedge clk);
        rxfifo_overflow = 1'b0;
        bus_wren = 1'b0;
        #1;
        checks++;
        if (bus_rddata !== 32'h4) begin
            failures++;
            $display("[TB] FAIL overflow_set_wins: got %h expected %h", bus_rddata, 32'h4);
        end
        busIdle();
        rx_framing_error = 1'b1;
        @(negedge clk);
        rx_framing_error = 1'b0;
        busSet(2'd0, 1'b1, 32'h8, 4'b1110);
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'hC) begin
            failures++;
            $display("[TB] FAIL framing_lane_masked: got %h expected %h", bus_rddata, 32'hC);
        end
        busSet(2'd0, 1'b1, 32'hC, 4'h1);
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL sticky_clear_both: got %h expected %h", bus_rddata, 32'h0);
        end
        busIdle();
    endtask

    task automatic test_irq();
        logic [31:0] ctrlExp;
        logic        irqLate;
        logic [31:0] statusLate;
`ifdef ESP_UART_IRQ_EN
        ctrlExp    = 32'h1;
        irqLate    = 1'b1;
        statusLate = 32'h11;
`else
        ctrlExp    = 32'h0;
        irqLate    = 1'b0;
        statusLate = 32'h01;
`endif
        busSet(2'd2, 1'b1, 32'h1, 4'h1);
        busSet(2'd2, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== ctrlExp) begin
            failures++;
            $display("[TB] FAIL ctrl_readback: got %h expected %h", bus_rddata, ctrlExp);
        end
        busIdle();
        pushRx(9'h033);
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h01 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_latency: got status=%h irq=%b expected 00000001 0", bus_rddata, irq);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus_rddata !== statusLate || irq !== irqLate) begin
            failures++;
            $display("[TB] FAIL irq_raised: got status=%h irq=%b expected %h %b",
                     bus_rddata, irq, statusLate, irqLate);
        end
        busSet(2'd1, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h033) begin
            failures++;
            $display("[TB] FAIL irq_data: got %h expected %h", bus_rddata, 32'h033);
        end
        busIdle();
        @(negedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_cleared: got %b expected 0", irq);
        end
        busSet(2'd2, 1'b1, 32'h0, 4'h1);
        busIdle();
    endtask

    task automatic test_reserved();
        busSet(2'd3, 1'b1, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (bus_wait !== 1'b0 || txfifo_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reserved_write: got wait=%b wr=%b expected 0 0", bus_wait, txfifo_wr);
        end
        busSet(2'd3, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reserved_read: got %h expected %h", bus_rddata, 32'h0);
        end
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reserved_no_effect: got %h expected %h", bus_rddata, 32'h0);
        end
        busIdle();
    endtask

    task automatic test_reset_mid_stall();
        int startTx;
        @(negedge clk);
        pushRx(9'h055);
        repeat (2) @(negedge clk);
        pushRx(9'h0F0);
        rxfifo_overflow = 1'b1;
        @(negedge clk);
        rxfifo_overflow = 1'b0;
        startTx = txCount;
        txfifo_full = 1'b1;
        busSet(2'd1, 1'b1, 32'h1AA, 4'h1);
        checks++;
        if (bus_wait !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_stall_wait: got %b expected 1", bus_wait);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_wait !== 1'b0 || txfifo_wr !== 1'b0 || rxfifo_rd !== 1'b0 ||
            irq !== 1'b0 || bus_rddata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_async: got wait=%b wr=%b rd=%b irq=%b rddata=%h expected all 0",
                     bus_wait, txfifo_wr, rxfifo_rd, irq, bus_rddata);
        end
        @(negedge clk);
        txfifo_full = 1'b0;
        #1;
        checks++;
        if (txfifo_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_tx_abort: got wr=%b expected 0", txfifo_wr);
        end
        @(negedge clk);
        bus_strobe = 1'b0;
        bus_wren   = 1'b0;
        reset_n    = 1'b1;
        busSet(2'd0, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h01 || txCount !== startTx) begin
            failures++;
            $display("[TB] FAIL reset_recover: got status=%h pushes=%0d expected 00000001 0",
                     bus_rddata, txCount - startTx);
        end
        busSet(2'd1, 1'b0, 32'h0, 4'hF);
        checks++;
        if (bus_rddata !== 32'h0F0) begin
            failures++;
            $display("[TB] FAIL reset_refill_data: got %h expected %h", bus_rddata, 32'h0F0);
        end
        busIdle();
    endtask

    // Scenario sequence; every wait is a fixed number of cycles.
    initial begin
        test_reset();
        test_rx_prefetch();
        test_back_to_back();
        test_tx_stall();
        test_errors();
        test_irq();
        test_reserved();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
